// File: rtl/eth_pcs_rx_block_lock_pkg.sv
// Shared 10GBASE-R PCS RX constants, sync-header helper and block-lock state type.
package eth_pcs_params;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;
  localparam int         W_SYNC    = 2;

  localparam int SH_VAL_TH     = 64;
  localparam int SH_INVAL_TH   = 16;
  localparam int W_SH_VAL_TH   = $clog2(SH_VAL_TH) + 1;
  localparam int W_SH_INVAL_TH = $clog2(SH_INVAL_TH) + 1;

  localparam int W_RX_GEARBOX_DATA      = 32;
  localparam int W_RX_GEARBOX_OFFSET    = $clog2(W_RX_GEARBOX_DATA);
  localparam int RX_GEARBOX_OFFSET_INIT = W_RX_GEARBOX_DATA - 2;

  typedef enum logic [1:0] {
    HUNT,
    LOCKED,
    WAIT
  } blk_lock_state_t;

  function automatic logic is_sync_valid(input logic [W_SYNC-1:0] sh);
    return (sh == SYNC_DATA) || (sh == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/eth_pcs_rx_block_lock_slip_ctrl.sv
// Gearbox bit-offset owner: decrements (with wrap) on each slip, pulses o_slip,
// and counts down the header strobes to ignore while the gearbox settles.
module eth_pcs_rx_slip_ctrl
  import eth_pcs_params::*;
#(
  parameter int W_DATA    = W_RX_GEARBOX_DATA,
  parameter int SLIP_WAIT = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_slip,
  input  logic                      i_sh_vld,
  input  logic                      i_wait_active,
  output logic [$clog2(W_DATA)-1:0] o_offset,
  output logic                      o_slip,
  output logic                      o_wait_last
);

  localparam int W_OFF  = $clog2(W_DATA);
  localparam int W_WAIT = (SLIP_WAIT < 1) ? 1 : $clog2(SLIP_WAIT + 1);

  localparam logic [W_OFF-1:0]  OFF_INIT  = W_OFF'(W_DATA - 2);
  localparam logic [W_OFF-1:0]  OFF_MAX   = W_OFF'(W_DATA - 1);
  localparam logic [W_WAIT-1:0] WAIT_INIT = W_WAIT'(SLIP_WAIT);
  localparam logic [W_WAIT-1:0] WAIT_ONE  = W_WAIT'(1);

  logic [W_OFF-1:0]  r_offset;
  logic              r_slip;
  logic [W_WAIT-1:0] r_wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_offset   <= OFF_INIT;
      r_slip     <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      r_slip <= i_slip;
      if (i_slip) begin
        r_offset   <= (r_offset == '0) ? OFF_MAX : r_offset - 1'b1;
        r_wait_cnt <= WAIT_INIT;
      end else if (i_wait_active && i_sh_vld && (r_wait_cnt != '0)) begin
        r_wait_cnt <= r_wait_cnt - 1'b1;
      end
    end
  end

  // The parent leaves WAIT on the strobe that consumes the last ignored slot,
  // so the very next strobe is already evaluated in HUNT.
  assign o_wait_last = (r_wait_cnt <= WAIT_ONE);
  assign o_offset    = r_offset;
  assign o_slip      = r_slip;

endmodule

// File: rtl/eth_pcs_rx_block_lock.sv
// 10GBASE-R RX block-lock FSM (HUNT/LOCKED/WAIT) with sync-header counters.
// Optional ETH_PCS_LOCK_STATS_EN adds a saturating lock-loss counter output.
module eth_pcs_rx_block_lock
  import eth_pcs_params::*;
#(
  parameter int W_DATA      = eth_pcs_params::W_RX_GEARBOX_DATA,
  parameter int SH_VAL_TH   = eth_pcs_params::SH_VAL_TH,
  parameter int SH_INVAL_TH = eth_pcs_params::SH_INVAL_TH,
  parameter int SLIP_WAIT   = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_sh_vld,
  input  logic [W_SYNC-1:0]         i_sh,
  output logic [$clog2(W_DATA)-1:0] o_offset,
  output logic                      o_slip,
  output logic                      o_block_lock
`ifdef ETH_PCS_LOCK_STATS_EN
  ,
  output logic [15:0]               o_lock_loss_cnt
`else
`endif
);

  localparam int W_SHC = $clog2(SH_VAL_TH) + 1;
  localparam int W_INV = $clog2(SH_INVAL_TH) + 1;

  localparam logic [W_SHC-1:0] SHC_TH = W_SHC'(SH_VAL_TH);
  localparam logic [W_INV-1:0] INV_TH = W_INV'(SH_INVAL_TH);

  localparam blk_lock_state_t POST_SLIP = (SLIP_WAIT == 0) ? HUNT : WAIT;

  blk_lock_state_t  r_state;
  logic [W_SHC-1:0] r_sh_cnt;
  logic [W_INV-1:0] r_inv_cnt;
  logic             r_block_lock;

  logic             w_sh_ok;
  logic             w_sh_bad;
  logic [W_SHC-1:0] w_sh_cnt_inc;
  logic [W_INV-1:0] w_inv_cnt_inc;
  logic             w_lock_loss;
  logic             w_slip_req;
  logic             w_wait_active;
  logic             w_wait_last;

  assign w_sh_ok       = i_sh_vld & is_sync_valid(i_sh);
  assign w_sh_bad      = i_sh_vld & ~is_sync_valid(i_sh);
  assign w_sh_cnt_inc  = r_sh_cnt + 1'b1;
  assign w_inv_cnt_inc = r_inv_cnt + {{(W_INV-1){1'b0}}, w_sh_bad};

  // Losing lock outranks a window that completes on the same strobe.
  assign w_lock_loss   = (r_state == LOCKED) & i_sh_vld & (w_inv_cnt_inc == INV_TH);
  assign w_slip_req    = ((r_state == HUNT) & w_sh_bad) | w_lock_loss;
  assign w_wait_active = (r_state == WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= HUNT;
      r_sh_cnt     <= '0;
      r_inv_cnt    <= '0;
      r_block_lock <= 1'b0;
    end else begin
      case (r_state)
        HUNT: begin
          if (w_sh_ok) begin
            if (w_sh_cnt_inc == SHC_TH) begin
              r_block_lock <= 1'b1;
              r_sh_cnt     <= '0;
              r_inv_cnt    <= '0;
              r_state      <= LOCKED;
            end else begin
              r_sh_cnt <= w_sh_cnt_inc;
            end
          end else if (w_sh_bad) begin
            r_sh_cnt  <= '0;
            r_inv_cnt <= '0;
            r_state   <= POST_SLIP;
          end
        end
        LOCKED: begin
          if (w_lock_loss) begin
            r_block_lock <= 1'b0;
            r_sh_cnt     <= '0;
            r_inv_cnt    <= '0;
            r_state      <= POST_SLIP;
          end else if (i_sh_vld) begin
            if (w_sh_cnt_inc == SHC_TH) begin
              r_sh_cnt  <= '0;
              r_inv_cnt <= '0;
            end else begin
              r_sh_cnt  <= w_sh_cnt_inc;
              r_inv_cnt <= w_inv_cnt_inc;
            end
          end
        end
        WAIT: begin
          if (i_sh_vld && w_wait_last) begin
            r_state <= HUNT;
          end
        end
        default: begin
          r_state <= HUNT;
        end
      endcase
    end
  end

  eth_pcs_rx_slip_ctrl #(
    .W_DATA    (W_DATA),
    .SLIP_WAIT (SLIP_WAIT)
  ) u_slip_ctrl (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_slip        (w_slip_req),
    .i_sh_vld      (i_sh_vld),
    .i_wait_active (w_wait_active),
    .o_offset      (o_offset),
    .o_slip        (o_slip),
    .o_wait_last   (w_wait_last)
  );

  assign o_block_lock = r_block_lock;

`ifdef ETH_PCS_LOCK_STATS_EN
  logic [15:0] r_lock_loss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_loss_cnt <= '0;
    end else if (w_lock_loss && (r_lock_loss_cnt != 16'hFFFF)) begin
      r_lock_loss_cnt <= r_lock_loss_cnt + 16'd1;
    end
  end

  assign o_lock_loss_cnt = r_lock_loss_cnt;
`else
`endif

endmodule

// File: tb/tb_eth_pcs_rx_block_lock.sv
// Directed bench for eth_pcs_rx_block_lock: acquisition, window monitoring,
// loss of lock, slip wrap sequence and asynchronous reset mid-WAIT.
module tb_eth_pcs_rx_block_lock;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_sh_vld;
  logic [1:0]  i_sh;
  logic [4:0]  o_offset;
  logic        o_slip;
  logic        o_block_lock;
`ifdef ETH_PCS_LOCK_STATS_EN
  logic [15:0] o_lock_loss_cnt;
`endif

  int n_cmp     = 0;
  int n_err     = 0;
  int slip_seen = 0;
  int s0;

  eth_pcs_rx_block_lock dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_sh_vld     (i_sh_vld),
    .i_sh         (i_sh),
    .o_offset     (o_offset),
    .o_slip       (o_slip),
    .o_block_lock (o_block_lock)
`ifdef ETH_PCS_LOCK_STATS_EN
    ,
    .o_lock_loss_cnt (o_lock_loss_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_slip) slip_seen++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [1:0] sh);
    i_sh_vld = 1'b1;
    i_sh     = sh;
    @(posedge clk);
    #1;
    i_sh_vld = 1'b0;
    i_sh     = 2'b00;
  endtask

  task automatic send_good(input int n);
    for (int k = 0; k < n; k++) send(k[0] ? 2'b10 : 2'b01);
  endtask

  task automatic send_bad(input int n);
    for (int k = 0; k < n; k++) send(k[0] ? 2'b11 : 2'b00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  initial begin
    rst_n    = 1'b0;
    i_sh_vld = 1'b0;
    i_sh     = 2'b00;
    idle(3);
    rst_n = 1'b1;
    idle(1);

    check("rst_offset", 32'(o_offset), 32'd30);
    check("rst_slip",   32'(o_slip), 32'd0);
    check("rst_lock",   32'(o_block_lock), 32'd0);
`ifdef ETH_PCS_LOCK_STATS_EN
    check("rst_loss_cnt", 32'(o_lock_loss_cnt), 32'd0);
`endif

    // Bad header on the bus while the strobe is low must be ignored.
    idle(3);
    check("idle_offset", 32'(o_offset), 32'd30);
    check("idle_no_slip", 32'(slip_seen), 32'd0);

    send_good(63);
    check("acq_lock_63", 32'(o_block_lock), 32'd0);
    send_good(1);
    check("acq_lock_64", 32'(o_block_lock), 32'd1);
    check("acq_offset", 32'(o_offset), 32'd30);
    check("acq_no_slip", 32'(slip_seen), 32'd0);

    // 15 bad at the end of one window, 15 at the start of the next.
    send_good(49);
    send_bad(15);
    check("win1_15bad_lock", 32'(o_block_lock), 32'd1);
    send_bad(15);
    send_good(49);
    check("win2_15bad_lock", 32'(o_block_lock), 32'd1);
    check("win_no_slip", 32'(slip_seen), 32'd0);

    s0 = slip_seen;
    send_good(4);
    send_bad(15);
    check("loss_15_lock", 32'(o_block_lock), 32'd1);
    send_bad(1);
    check("loss_16_lock", 32'(o_block_lock), 32'd0);
    check("loss_slip", 32'(o_slip), 32'd1);
    check("loss_offset", 32'(o_offset), 32'd29);
    idle(1);
    check("loss_slip_one_cycle", 32'(o_slip), 32'd0);
    check("loss_slip_count", 32'(slip_seen - s0), 32'd1);
`ifdef ETH_PCS_LOCK_STATS_EN
    check("loss_cnt_1", 32'(o_lock_loss_cnt), 32'd1);
`endif

    send_bad(2);
    check("wait_offset", 32'(o_offset), 32'd29);
    check("wait_slip_count", 32'(slip_seen - s0), 32'd1);
    send_good(63);
    check("relock_63", 32'(o_block_lock), 32'd0);
    send_good(1);
    check("relock_64", 32'(o_block_lock), 32'd1);

    // 16th bad header lands on the window's final strobe.
    send_good(48);
    send_bad(15);
    check("prio_63_lock", 32'(o_block_lock), 32'd1);
    send_bad(1);
    check("prio_64_lock", 32'(o_block_lock), 32'd0);
    check("prio_offset", 32'(o_offset), 32'd28);
`ifdef ETH_PCS_LOCK_STATS_EN
    check("loss_cnt_2", 32'(o_lock_loss_cnt), 32'd2);
`endif

    do_reset();
    check("seq_rst_offset", 32'(o_offset), 32'd30);
    s0 = slip_seen;
    for (int i = 0; i < 31; i++) begin
      send_bad(1);
      check($sformatf("slip_seq%0d", i), 32'(o_offset), (i < 30) ? 32'(29 - i) : 32'd31);
      send_good(2);
    end
    check("seq_slip_count", 32'(slip_seen - s0), 32'd31);
    check("seq_lock", 32'(o_block_lock), 32'd0);

    do_reset();
    send_bad(1);
    check("wrst_pre_offset", 32'(o_offset), 32'd29);
    idle(3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("wrst_offset", 32'(o_offset), 32'd30);
    check("wrst_lock", 32'(o_block_lock), 32'd0);
    check("wrst_slip", 32'(o_slip), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    s0 = slip_seen;
    for (int k = 0; k < 63; k++) begin
      send(k[0] ? 2'b10 : 2'b01);
      if ((k % 8) == 7) idle(1);
    end
    check("wrst_hunt_63", 32'(o_block_lock), 32'd0);
    send(2'b01);
    check("wrst_hunt_64", 32'(o_block_lock), 32'd1);
    check("wrst_end_offset", 32'(o_offset), 32'd30);
    check("wrst_no_slip", 32'(slip_seen - s0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
